mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max ACCESS-state cycles waiting for dmem_ack (legal range 2..255).
REQ-002 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  execute-stage outputs valid this cycle.
REQ-005 SHALL have port alu_result  in  32  ALU result; memory address for loads/stores.
REQ-006 SHALL have port store_data  in  32  register-file read data 2; store data.
REQ-007 SHALL have port zero  in  1  ALU zero flag.
REQ-008 SHALL have port branch_target  in  32  computed branch address.
REQ-009 SHALL have ports ctrl_memRead, ctrl_memWrite, ctrl_branch, ctrl_memToReg, ctrl_regWrite  in  1 each  decoded control.
REQ-010 SHALL have port write_reg  in  5  destination register.
REQ-011 SHALL have ports dmem_req, dmem_we  out  1 each  memory request / write enable.
REQ-012 SHALL have ports dmem_addr, dmem_wdata  out  32 each  address / write data.
REQ-013 SHALL have ports dmem_rdata  in  32, dmem_ack  in  1  read data / completion.
REQ-014 SHALL have port stall  out  1  upstream must hold inputs.
REQ-015 SHALL have ports pc_src  out  1, branch_addr  out  32  branch-taken select and target.
REQ-016 SHALL have ports wb_valid  out  1, wb_data  out  32, wb_reg  out  5, wb_regWrite  out  1  write-back bundle.
REQ-017 SHALL have ports misaligned_fault, bus_fault  out  1 each  one-cycle fault pulses.

Function
REQ-018 SHALL implement FSM states IDLE and ACCESS; reset state IDLE.
REQ-019 SHALL accept inputs in IDLE when in_valid=1; stall SHALL equal (state==ACCESS), combinational.
REQ-020 Accepted non-memory op (memRead=memWrite=0): wb_valid=1 next cycle, wb_data=alu_result, wb_reg=write_reg, wb_regWrite=ctrl_regWrite; latency 1.
REQ-021 Accepted memory op with alu_result[1:0]=0: next cycle enter ACCESS, dmem_req=1, dmem_addr=alu_result, dmem_wdata=store_data, dmem_we=ctrl_memWrite; all latched.
REQ-022 If memRead and memWrite both 1, write SHALL take priority (dmem_we=1), no read data captured.
REQ-023 dmem_req/dmem_we/dmem_addr/dmem_wdata SHALL remain stable throughout ACCESS until ack.
REQ-024 dmem_ack SHALL be sampled only in ACCESS; ack in IDLE ignored.
REQ-025 On ack in ACCESS: dmem_req=0 and return to IDLE next cycle; wb_valid=1 same next cycle; wb_data=dmem_rdata if read and memToReg=1, else latched alu_result.
REQ-026 Minimum memory-op latency: accept edge -> wb_valid = 2 cycles with ack on first ACCESS cycle.
REQ-027 8-bit wait counter SHALL clear on ACCESS entry, increment each ACCESS cycle without ack; at count TIMEOUT-1 without ack: return IDLE, dmem_req=0, bus_fault pulse 1 cycle, wb_valid=1 with wb_regWrite=0.
REQ-028 Ack on the same cycle as timeout SHALL win (normal completion, no bus_fault).
REQ-029 Misaligned memory op (alu_result[1:0]!=0): no dmem_req, stay IDLE, next cycle misaligned_fault=1, wb_valid=1, wb_regWrite=0.
REQ-030 pc_src SHALL be registered: 1 for one cycle after acceptance with ctrl_branch=1 and zero=1; branch_addr=branch_target latched same edge, held otherwise.
REQ-031 wb_valid, pc_src and fault pulses SHALL be 1 for exactly one cycle per accepted op.
REQ-032 in_valid while stall=1 SHALL not be accepted; new ops accepted on the IDLE-return cycle.

Reset
REQ-033 reset=0 SHALL asynchronously force state IDLE, counter 0, and all outputs 0 (including dmem_req, dmem_we, dmem_addr, dmem_wdata, branch_addr, wb_data, wb_reg).
REQ-034 Reset during ACCESS SHALL drop dmem_req immediately and discard the transaction with no wb_valid or fault afterwards.

Verification
REQ-035 ALU op: in_valid=1, alu_result=0x0000_0005, regWrite=1, write_reg=3 -> next cycle wb_valid=1, wb_data=5, wb_reg=3, stall=0.
REQ-036 Load: alu_result=0x100, memRead=1, memToReg=1; ack after 3 ACCESS cycles with rdata=0xDEADBEEF -> stall=1 for 3 cycles, addr=0x100 stable, then wb_data=0xDEADBEEF.
REQ-037 Store: alu_result=0x204, store_data=0x55, memWrite=1, ack first cycle -> dmem_we=1, dmem_wdata=0x55, wb_regWrite=0.
REQ-038 Timeout: TIMEOUT=4, load with no ack -> dmem_req high 4 cycles, then bus_fault 1 cycle, wb_regWrite=0, state IDLE.
REQ-039 Misaligned load alu_result=0x102 -> dmem_req never 1, misaligned_fault=1 next cycle; branch=1, zero=1, target=0x40 -> pc_src=1, branch_addr=0x40 next cycle.
REQ-040 reset=0 mid-ACCESS -> dmem_req=0 immediately, no wb_valid after release.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage.
//   Takes execute-stage results, runs loads/stores on a request/ack data bus
//   and produces a one-cycle write-back bundle per accepted operation.
//   Ports:
//     clk, reset (async, active-low)
//     in_valid, alu_result, store_data, zero, branch_target, ctrl_*, write_reg
//                                               - execute-stage inputs
//     dmem_req/we/addr/wdata (out), dmem_rdata/ack (in)  - data memory bus
//     stall                                     - upstream must hold inputs
//     pc_src, branch_addr                       - registered branch redirect
//     wb_valid, wb_data, wb_reg, wb_regWrite    - write-back bundle
//     misaligned_fault, bus_fault               - one-cycle fault pulses
module mem_access #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic        zero,
   input  logic [31:0] branch_target,
   input  logic        ctrl_memRead,
   input  logic        ctrl_memWrite,
   input  logic        ctrl_branch,
   input  logic        ctrl_memToReg,
   input  logic        ctrl_regWrite,
   input  logic [4:0]  write_reg,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        pc_src,
   output logic [31:0] branch_addr,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_reg,
   output logic        wb_regWrite,
   output logic        misaligned_fault,
   output logic        bus_fault
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;
   localparam logic [7:0] LAST   = 8'(TIMEOUT - 1);

   logic [0:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic        rd_q, rd_d, m2r_q, m2r_d, rw_q, rw_d;
   logic [4:0]  reg_q, reg_d;
   logic        wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [4:0]  wb_reg_q, wb_reg_d;
   logic        pc_src_q, pc_src_d;
   logic [31:0] baddr_q, baddr_d;
   logic        mis_q, mis_d, bus_q, bus_d;

   logic accept, mem_op, taken;

   assign accept = (state_q == IDLE) && in_valid;
   assign mem_op = ctrl_memRead | ctrl_memWrite;
   assign taken  = ctrl_branch & zero;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      m2r_d      = m2r_q;
      rw_d       = rw_q;
      reg_d      = reg_q;
      wb_data_d  = wb_data_q;
      wb_reg_d   = wb_reg_q;
      wb_rw_d    = wb_rw_q;
      baddr_d    = baddr_q;
      // pulses default low every cycle
      wb_valid_d = 1'b0;
      pc_src_d   = 1'b0;
      mis_d      = 1'b0;
      bus_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               pc_src_d = taken;
               if (taken) baddr_d = branch_target;
               if (!mem_op) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = alu_result;
                  wb_reg_d   = write_reg;
                  wb_rw_d    = ctrl_regWrite;
               end else if (alu_result[1:0] != 2'b00) begin
                  // misaligned: report and retire without touching the bus
                  wb_valid_d = 1'b1;
                  mis_d      = 1'b1;
                  wb_data_d  = alu_result;
                  wb_reg_d   = write_reg;
                  wb_rw_d    = 1'b0;
               end else begin
                  state_d = ACCESS;
                  cnt_d   = 8'd0;
                  req_d   = 1'b1;
                  we_d    = ctrl_memWrite;
                  addr_d  = alu_result;
                  wdata_d = store_data;
                  // write wins when both read and write are set
                  rd_d    = ctrl_memRead & ~ctrl_memWrite;
                  m2r_d   = ctrl_memToReg;
                  rw_d    = ctrl_regWrite;
                  reg_d   = write_reg;
               end
            end
         end
         ACCESS: begin
            // ack beats timeout when both land on the same cycle
            if (dmem_ack) begin
               state_d    = IDLE;
               req_d      = 1'b0;
               we_d       = 1'b0;
               wb_valid_d = 1'b1;
               wb_data_d  = (rd_q && m2r_q) ? dmem_rdata : addr_q;
               wb_reg_d   = reg_q;
               wb_rw_d    = rw_q;
            end else if (cnt_q == LAST) begin
               state_d    = IDLE;
               req_d      = 1'b0;
               we_d       = 1'b0;
               bus_d      = 1'b1;
               wb_valid_d = 1'b1;
               wb_data_d  = addr_q;
               wb_reg_d   = reg_q;
               wb_rw_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         rd_q       <= 1'b0;
         m2r_q      <= 1'b0;
         rw_q       <= 1'b0;
         reg_q      <= 5'd0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= 32'd0;
         wb_reg_q   <= 5'd0;
         wb_rw_q    <= 1'b0;
         pc_src_q   <= 1'b0;
         baddr_q    <= 32'd0;
         mis_q      <= 1'b0;
         bus_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         m2r_q      <= m2r_d;
         rw_q       <= rw_d;
         reg_q      <= reg_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_reg_q   <= wb_reg_d;
         wb_rw_q    <= wb_rw_d;
         pc_src_q   <= pc_src_d;
         baddr_q    <= baddr_d;
         mis_q      <= mis_d;
         bus_q      <= bus_d;
      end
   end

   assign stall            = (state_q == ACCESS);
   assign dmem_req         = req_q;
   assign dmem_we          = we_q;
   assign dmem_addr        = addr_q;
   assign dmem_wdata       = wdata_q;
   assign pc_src           = pc_src_q;
   assign branch_addr      = baddr_q;
   assign wb_valid         = wb_valid_q;
   assign wb_data          = wb_data_q;
   assign wb_reg           = wb_reg_q;
   assign wb_regWrite      = wb_rw_q;
   assign misaligned_fault = mis_q;
   assign bus_fault        = bus_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed stimulus with a queue scoreboard for mem_access.
//   Stimulus pushes the expected write-back bundle; a negedge monitor pops
//   and compares whenever wb_valid is seen. Bus-side behaviour (stall,
//   request stability, reset response) is checked inline by the stimulus.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] alu_result = '0, store_data = '0, branch_target = '0;
   logic        zero = 1'b0;
   logic        ctrl_memRead = 1'b0, ctrl_memWrite = 1'b0, ctrl_branch = 1'b0;
   logic        ctrl_memToReg = 1'b0, ctrl_regWrite = 1'b0;
   logic [4:0]  write_reg = '0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ack = 1'b0;
   logic        stall, pc_src;
   logic [31:0] branch_addr, wb_data;
   logic        wb_valid, wb_regWrite, misaligned_fault, bus_fault;
   logic [4:0]  wb_reg;

   mem_access #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
      .store_data(store_data), .zero(zero), .branch_target(branch_target),
      .ctrl_memRead(ctrl_memRead), .ctrl_memWrite(ctrl_memWrite),
      .ctrl_branch(ctrl_branch), .ctrl_memToReg(ctrl_memToReg),
      .ctrl_regWrite(ctrl_regWrite), .write_reg(write_reg),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall(stall), .pc_src(pc_src), .branch_addr(branch_addr),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
      .wb_regWrite(wb_regWrite), .misaligned_fault(misaligned_fault),
      .bus_fault(bus_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rg;
      logic        rw;
      logic        mf;
      logic        bf;
      logic        pc;
      logic [31:0] baddr;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [4:0] r, input logic rw,
                       input logic mf, input logic bf, input logic pc, input logic [31:0] ba);
      exp_t e;
      e.data = d; e.rg = r; e.rw = rw; e.mf = mf; e.bf = bf; e.pc = pc; e.baddr = ba;
      sb.push_back(e);
   endtask

   // Called at posedge+1; presents one op for a single accept edge.
   task automatic drive(input logic rd, input logic wr, input logic br, input logic m2r,
                        input logic rw, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [31:0] tgt, input logic z, input logic [4:0] wreg);
      ctrl_memRead = rd; ctrl_memWrite = wr; ctrl_branch = br; ctrl_memToReg = m2r;
      ctrl_regWrite = rw; alu_result = alu; store_data = sd; branch_target = tgt;
      zero = z; write_reg = wreg; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; ctrl_memRead = 1'b0; ctrl_memWrite = 1'b0; ctrl_branch = 1'b0;
      ctrl_memToReg = 1'b0; ctrl_regWrite = 1'b0; zero = 1'b0;
   endtask

   // Monitor: pops one expectation per wb_valid; pulses must coincide with it.
   exp_t me;
   always @(negedge clk) begin
      if (wb_valid) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL wb_unexpected: got wb_valid=1 data=0x%08h expected none", wb_data);
         end else begin
            me = sb.pop_front();
            chk("wb_data", wb_data, me.data);
            chk("wb_reg", {27'd0, wb_reg}, {27'd0, me.rg});
            chk("wb_regWrite", {31'd0, wb_regWrite}, {31'd0, me.rw});
            chk("misaligned_fault", {31'd0, misaligned_fault}, {31'd0, me.mf});
            chk("bus_fault", {31'd0, bus_fault}, {31'd0, me.bf});
            chk("pc_src", {31'd0, pc_src}, {31'd0, me.pc});
            if (me.pc) chk("branch_addr", branch_addr, me.baddr);
         end
      end else begin
         chk("pulse_without_wb", {29'd0, pc_src, misaligned_fault, bus_fault}, 32'd0);
      end
   end

   initial begin
      int n;
      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_dmem_wdata", dmem_wdata, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_branch_addr", branch_addr, 32'd0);
      @(posedge clk); #1 reset = 1'b1;

      // ALU op
      push(32'h5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(0, 0, 0, 0, 1, 32'h5, 32'h0, 32'h0, 0, 5'd3);
      @(negedge clk);
      chk("alu_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;

      // taken branch, then untaken branch
      push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
      drive(0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h40, 1, 5'd0);
      push(32'h8, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(0, 0, 1, 0, 1, 32'h8, 32'h0, 32'h80, 0, 5'd1);
      @(posedge clk); #1;
      chk("branch_addr_held", branch_addr, 32'h40);

      // load, ack on third ACCESS cycle
      push(32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1, 0, 0, 1, 1, 32'h100, 32'h0, 32'h0, 0, 5'd7);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
         @(negedge clk);
         chk("ld_stall", {31'd0, stall}, 32'd1);
         chk("ld_req", {31'd0, dmem_req}, 32'd1);
         chk("ld_we", {31'd0, dmem_we}, 32'd0);
         chk("ld_addr", dmem_addr, 32'h100);
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      @(negedge clk);
      chk("ld_done_stall", {31'd0, stall}, 32'd0);
      chk("ld_done_req", {31'd0, dmem_req}, 32'd0);
      @(posedge clk); #1;

      // store, ack on first ACCESS cycle
      push(32'h204, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(0, 1, 0, 0, 0, 32'h204, 32'h55, 32'h0, 0, 5'd2);
      dmem_ack = 1'b1;
      @(negedge clk);
      chk("st_req", {31'd0, dmem_req}, 32'd1);
      chk("st_we", {31'd0, dmem_we}, 32'd1);
      chk("st_wdata", dmem_wdata, 32'h55);
      chk("st_addr", dmem_addr, 32'h204);
      @(posedge clk); #1 dmem_ack = 1'b0;
      @(negedge clk);
      chk("st_done_req", {31'd0, dmem_req}, 32'd0);
      @(posedge clk); #1;

      // read+write together: write wins, read data not captured
      push(32'h300, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1, 1, 0, 1, 1, 32'h300, 32'h77, 32'h0, 0, 5'd4);
      dmem_ack = 1'b1; dmem_rdata = 32'hAAAA5555;
      @(negedge clk);
      chk("rw_we", {31'd0, dmem_we}, 32'd1);
      @(posedge clk); #1 dmem_ack = 1'b0; dmem_rdata = 32'h0;
      @(posedge clk); #1;

      // timeout: no ack, req high for TIMEOUT cycles then bus_fault
      push(32'h400, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      drive(1, 0, 0, 1, 1, 32'h400, 32'h0, 32'h0, 0, 5'd9);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!dmem_req) break;
         n++;
         @(posedge clk); #1;
      end
      chk("to_req_cycles", n, 32'd4);
      chk("to_stall_after", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;

      // ack on the timeout cycle wins
      push(32'h1234, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1, 0, 0, 1, 1, 32'h500, 32'h0, 32'h0, 0, 5'd10);
      repeat (3) begin @(posedge clk); #1; end
      dmem_ack = 1'b1; dmem_rdata = 32'h1234;
      @(negedge clk);
      chk("tw_req_last", {31'd0, dmem_req}, 32'd1);
      @(posedge clk); #1 dmem_ack = 1'b0; dmem_rdata = 32'h0;
      @(posedge clk); #1;

      // ack while idle is ignored (monitor flags any stray wb_valid)
      dmem_ack = 1'b1;
      @(posedge clk); #1 dmem_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;

      // misaligned load
      push(32'h102, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      drive(1, 0, 0, 1, 1, 32'h102, 32'h0, 32'h0, 0, 5'd5);
      @(negedge clk);
      chk("mis_req", {31'd0, dmem_req}, 32'd0);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_req2", {31'd0, dmem_req}, 32'd0);
      @(posedge clk); #1;

      // op held during stall is accepted only on the IDLE-return cycle
      push(32'hCAFE, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      push(32'h99, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1, 0, 0, 1, 1, 32'h600, 32'h0, 32'h0, 0, 5'd8);
      ctrl_regWrite = 1'b1; alu_result = 32'h99; write_reg = 5'd11; in_valid = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE;
      @(negedge clk);
      chk("hold_addr", dmem_addr, 32'h600);
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      @(posedge clk); #1;
      in_valid = 1'b0; ctrl_regWrite = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // reset in ACCESS: request drops at once, nothing retires afterwards
      drive(1, 0, 0, 1, 1, 32'h700, 32'h0, 32'h0, 0, 5'd12);
      @(negedge clk);
      chk("rstacc_req_before", {31'd0, dmem_req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rstacc_req_now", {31'd0, dmem_req}, 32'd0);
      chk("rstacc_stall_now", {31'd0, stall}, 32'd0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b1;
      repeat (6) begin @(posedge clk); #1; end

      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
